// File: rtl/ex_muldiv_stage_if.sv
// rtl/ex_muldiv_stage_if.sv - ID/EX in, EX/MEM out and hazard signals of the execute stage
//
// Purpose: groups everything the execute stage exchanges with the pipeline
// apart from clk/rst_n.
//   in_*          ID/EX bundle fields (in_muldiv marks an M op, in_funct3 selects it)
//   in_valid      EX slot holds a real instruction
//   forwarda/b    forwarding selects (00 reg file, 01 WB result, 10 MEM result)
//   result_w      forwarded WB value
//   aluresult_m   forwarded MEM value
//   flush_e       kill the EX instruction, aborts any M op
//   hold_e        downstream stall, EX/MEM register frozen
//   stall_e       EX requests a freeze of IF/ID/EX
//   pctarget      in_pc + in_immext
//   pcsrc         branch/jump taken
//   out_*         EX/MEM bundle fields
// master: the pipeline side driving ID/EX; slave: the execute stage.
interface ex_muldiv_stage_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_immext;
   logic [XLEN-1:0] in_rd1;
   logic [XLEN-1:0] in_rd2;
   logic [XLEN-1:0] in_pcplus4;
   logic [2:0]      in_alucontrol;
   logic            in_alusrc;
   logic            in_branch;
   logic            in_jump;
   logic [2:0]      in_funct3;
   logic            in_muldiv;
   logic [4:0]      in_rd;
   logic            in_regwrite;
   logic            in_memwrite;
   logic            in_valid;
   logic [1:0]      forwarda;
   logic [1:0]      forwardb;
   logic [XLEN-1:0] result_w;
   logic [XLEN-1:0] aluresult_m;
   logic            flush_e;
   logic            hold_e;
   logic            stall_e;
   logic [XLEN-1:0] pctarget;
   logic            pcsrc;
   logic [XLEN-1:0] out_aluresult;
   logic [XLEN-1:0] out_writedata;
   logic [XLEN-1:0] out_pcplus4;
   logic [4:0]      out_rd;
   logic            out_regwrite;
   logic            out_memwrite;

   modport master (
      output in_pc, in_immext, in_rd1, in_rd2, in_pcplus4, in_alucontrol, in_alusrc,
             in_branch, in_jump, in_funct3, in_muldiv, in_rd, in_regwrite, in_memwrite,
             in_valid, forwarda, forwardb, result_w, aluresult_m, flush_e, hold_e,
      input  stall_e, pctarget, pcsrc, out_aluresult, out_writedata, out_pcplus4,
             out_rd, out_regwrite, out_memwrite
   );

   modport slave (
      input  in_pc, in_immext, in_rd1, in_rd2, in_pcplus4, in_alucontrol, in_alusrc,
             in_branch, in_jump, in_funct3, in_muldiv, in_rd, in_regwrite, in_memwrite,
             in_valid, forwarda, forwardb, result_w, aluresult_m, flush_e, hold_e,
      output stall_e, pctarget, pcsrc, out_aluresult, out_writedata, out_pcplus4,
             out_rd, out_regwrite, out_memwrite
   );
endinterface

// File: rtl/ex_muldiv_stage.sv
// rtl/ex_muldiv_stage.sv - execute stage with single-cycle ALU and iterative RV32M/RV64M unit
//
// Purpose: ALU, branch resolution and operand forwarding, plus a multi-cycle
// multiply/divide unit that freezes the front of the pipeline via stall_e.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   bus_io  ex_muldiv_stage_if.slave (ID/EX in, EX/MEM out, hazard signals)
// Parameters: XLEN (32/64), MUL_BITS (1/2/4/8, divides XLEN).
// Optional feature: EX_MUL_EARLY_OUT_EN lets a multiply leave BUSY once the
// remaining multiplier magnitude is zero.
module ex_muldiv_stage #(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   ex_muldiv_stage_if.slave bus_io
);
   localparam int            CW        = $clog2(XLEN + 1);
   localparam logic [CW-1:0] MUL_STEPS = CW'(XLEN / MUL_BITS);
   localparam logic [CW-1:0] DIV_STEPS = CW'(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state_q, state_d;

   logic [XLEN-1:0]   srca, wdata, srcb, alu_res;
   logic [2:0]        f3;
   logic              is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, special, start;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2*XLEN-1:0] acc_q, mcs_q, partial, prod_s;
   logic [XLEN-1:0]   mq_q, dres, m_res;
   logic [CW-1:0]     cnt_q;
   logic [2:0]        f3_q;
   logic              neg_q, last_step, stall_c, m_done;
   logic [XLEN:0]     trial;
   logic [2*XLEN-1:0] div_next;

   // Forwarding and single-cycle ALU
   always_comb begin
      srca = bus_io.in_rd1;
      case (bus_io.forwarda)
         2'b01:   srca = bus_io.result_w;
         2'b10:   srca = bus_io.aluresult_m;
         default: srca = bus_io.in_rd1;
      endcase
      wdata = bus_io.in_rd2;
      case (bus_io.forwardb)
         2'b01:   wdata = bus_io.result_w;
         2'b10:   wdata = bus_io.aluresult_m;
         default: wdata = bus_io.in_rd2;
      endcase
      srcb = bus_io.in_alusrc ? bus_io.in_immext : wdata;
      case (bus_io.in_alucontrol)
         3'b001:  alu_res = srca - srcb;
         3'b010:  alu_res = srca & srcb;
         3'b011:  alu_res = srca | srcb;
         3'b100:  alu_res = srca ^ srcb;
         3'b101:  alu_res = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
         3'b110:  alu_res = {{(XLEN-1){1'b0}}, srca < srcb};
         default: alu_res = srca + srcb;
      endcase
   end

   assign bus_io.pctarget = bus_io.in_pc + bus_io.in_immext;
   assign bus_io.pcsrc    = bus_io.in_valid & (bus_io.in_jump | (bus_io.in_branch & (alu_res == '0)));

   // M op decode: signed operands are a for {MUL,MULH,MULHSU,DIV,REM}, b for {MUL,MULH,DIV,REM}
   assign f3       = bus_io.in_funct3;
   assign is_div   = f3[2];
   assign a_sgn    = (f3 != 3'd3) & ~(f3[2] & f3[0]);
   assign b_sgn    = f3[2] ? ~f3[0] : ~f3[1];
   assign a_neg    = a_sgn & srca[XLEN-1];
   assign b_neg    = b_sgn & wdata[XLEN-1];
   assign a_mag    = a_neg ? -srca : srca;
   assign b_mag    = b_neg ? -wdata : wdata;
   assign div_zero = (wdata == '0);
   assign div_ovf  = b_sgn & (srca == MIN_NEG) & (&wdata);
   assign special  = is_div & (div_zero | div_ovf);
   assign start    = bus_io.in_valid & bus_io.in_muldiv & ~bus_io.flush_e;

   // Shift-add: add the multiplicand (already shifted to the current digit) once per set digit bit
   always_comb begin
      partial = '0;
      for (int i = 0; i < MUL_BITS; i++)
         if (mq_q[i]) partial = partial + (mcs_q << i);
   end

   // Restoring divide on acc = {remainder, quotient}; the extra top bit covers divisors >= 2^(XLEN-1)
   assign trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mcs_q[XLEN-1:0]};
   assign div_next = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                 : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

`ifdef EX_MUL_EARLY_OUT_EN
   assign last_step = (cnt_q == CW'(1)) | (~f3_q[2] & (mq_q == '0));
`else
   assign last_step = (cnt_q == CW'(1));
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = special ? DONE : BUSY;
         BUSY:    if (last_step) state_d = DONE;
         DONE:    if (!bus_io.hold_e) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus_io.flush_e) state_d = IDLE;
   end

   // FSM outputs
   always_comb begin
      stall_c = 1'b0;
      m_done  = 1'b0;
      case (state_q)
         IDLE:    stall_c = start;
         BUSY:    stall_c = ~bus_io.flush_e;
         DONE:    m_done  = 1'b1;
         default: stall_c = 1'b0;
      endcase
   end

   // M datapath; specials preload {remainder, quotient} with no sign fix
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         mcs_q <= '0;
         mq_q  <= '0;
         cnt_q <= '0;
         f3_q  <= '0;
         neg_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         f3_q  <= f3;
         cnt_q <= is_div ? DIV_STEPS : MUL_STEPS;
         mq_q  <= b_mag;
         if (!is_div) begin
            acc_q <= '0;
            mcs_q <= {{XLEN{1'b0}}, a_mag};
            neg_q <= a_neg ^ b_neg;
         end else if (div_zero) begin
            acc_q <= {srca, {XLEN{1'b1}}};
            neg_q <= 1'b0;
         end else if (div_ovf) begin
            acc_q <= {{XLEN{1'b0}}, srca};
            neg_q <= 1'b0;
         end else begin
            acc_q <= {{XLEN{1'b0}}, a_mag};
            mcs_q <= {{XLEN{1'b0}}, b_mag};
            neg_q <= f3[1] ? a_neg : (a_neg ^ b_neg);
         end
      end else if (state_q == BUSY) begin
         cnt_q <= cnt_q - CW'(1);
         if (!f3_q[2]) begin
            acc_q <= acc_q + partial;
            mcs_q <= mcs_q << MUL_BITS;
            mq_q  <= mq_q >> MUL_BITS;
         end else begin
            acc_q <= div_next;
         end
      end
   end

   // Result: MUL low half, MULH* high half; REM picks the remainder half
   always_comb begin
      prod_s = neg_q ? -acc_q : acc_q;
      dres   = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      if (f3_q[2])             m_res = neg_q ? -dres : dres;
      else if (f3_q == 3'd0)   m_res = prod_s[XLEN-1:0];
      else                     m_res = prod_s[2*XLEN-1:XLEN];
   end

   assign bus_io.stall_e       = stall_c;
   assign bus_io.out_aluresult = m_done ? m_res : alu_res;
   assign bus_io.out_writedata = wdata;
   assign bus_io.out_pcplus4   = bus_io.in_pcplus4;
   assign bus_io.out_rd        = bus_io.in_rd;
   assign bus_io.out_regwrite  = bus_io.in_regwrite;
   assign bus_io.out_memwrite  = bus_io.in_memwrite;
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb/tb_ex_muldiv_stage.sv - directed self-checking bench for ex_muldiv_stage
module tb_ex_muldiv_stage;
   logic clk = 1'b0;
   logic rst_n;
   int   n_pass = 0;
   int   n_fail = 0;
   int   n_total = 0;
   int   st;

   always #5 clk = ~clk;

   ex_muldiv_stage_if #(.XLEN(32)) bus_io ();

   ex_muldiv_stage #(.XLEN(32), .MUL_BITS(1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus_io)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected stall_e cycles for a multiply with multiplier magnitude bmag
   function automatic int mul_stalls(input logic [31:0] bmag);
`ifdef EX_MUL_EARLY_OUT_EN
      int n = 0;
      logic [31:0] m = bmag;
      while (m != 0) begin
         n++;
         m = m >> 1;
      end
      return 1 + ((n + 1 > 32) ? 32 : n + 1);
`else
      return 1 + 32;
`endif
   endfunction

   // Present an M op and wait (bounded) until stall_e drops; returns in the DONE cycle.
   // The MEM forward value is scrambled after the start edge to prove operands were latched.
   task automatic issue_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int stalls);
      bus_io.in_valid  = 1'b1;
      bus_io.in_muldiv = 1'b1;
      bus_io.in_funct3 = f3;
      bus_io.in_rd1    = a;
      bus_io.in_rd2    = b;
      stalls = 0;
      #1;
      while (bus_io.stall_e === 1'b1 && stalls < 200) begin
         stalls++;
         @(posedge clk);
         #1;
         bus_io.aluresult_m = 32'hdead_0055;
         #1;
      end
   endtask

   task automatic retire();
      step();
      bus_io.in_valid  = 1'b0;
      bus_io.in_muldiv = 1'b0;
   endtask

   initial begin
      rst_n                = 1'b0;
      bus_io.in_pc         = 32'h100;
      bus_io.in_immext     = 32'h20;
      bus_io.in_rd1        = 32'd5;
      bus_io.in_rd2        = 32'd3;
      bus_io.in_pcplus4    = 32'h104;
      bus_io.in_alucontrol = 3'b000;
      bus_io.in_alusrc     = 1'b0;
      bus_io.in_branch     = 1'b0;
      bus_io.in_jump       = 1'b0;
      bus_io.in_funct3     = 3'd0;
      bus_io.in_muldiv     = 1'b0;
      bus_io.in_rd         = 5'd7;
      bus_io.in_regwrite   = 1'b1;
      bus_io.in_memwrite   = 1'b0;
      bus_io.in_valid      = 1'b0;
      bus_io.forwarda      = 2'b00;
      bus_io.forwardb      = 2'b00;
      bus_io.result_w      = 32'h0;
      bus_io.aluresult_m   = 32'h0;
      bus_io.flush_e       = 1'b0;
      bus_io.hold_e        = 1'b0;
      step();
      step();

      // Reset state: no stall, outputs purely combinational from in
      chk("rst_stall", {31'b0, bus_io.stall_e}, 32'd0);
      chk("rst_alu", bus_io.out_aluresult, 32'd8);
      chk("rst_pctarget", bus_io.pctarget, 32'h120);
      rst_n = 1'b1;
      step();

      // ADD 5+3, single cycle, no stall over two cycles
      bus_io.in_valid = 1'b1;
      #1;
      chk("add_res", bus_io.out_aluresult, 32'd8);
      chk("add_stall0", {31'b0, bus_io.stall_e}, 32'd0);
      step();
      chk("add_stall1", {31'b0, bus_io.stall_e}, 32'd0);
      chk("add_rd", {27'b0, bus_io.out_rd}, 32'd7);

      // Branch: BEQ 4==4 taken, 4!=5 not taken
      bus_io.in_branch = 1'b1;
      bus_io.in_alucontrol = 3'b001;
      bus_io.in_rd1 = 32'd4;
      bus_io.in_rd2 = 32'd4;
      #1;
      chk("beq_taken", {31'b0, bus_io.pcsrc}, 32'd1);
      bus_io.in_rd2 = 32'd5;
      #1;
      chk("beq_not_taken", {31'b0, bus_io.pcsrc}, 32'd0);
      bus_io.in_branch = 1'b0;
      bus_io.in_alucontrol = 3'b000;
      step();

      // Multiplies (the second and later ones start back-to-back after DONE)
      issue_m(3'd0, 32'd7, 32'hffff_fffd, st);
      chk("mul_stalls", st, mul_stalls(32'd3));
      chk("mul_res", bus_io.out_aluresult, 32'hffff_ffeb);
      chk("mul_done_stall", {31'b0, bus_io.stall_e}, 32'd0);
      retire();
      issue_m(3'd3, 32'hffff_ffff, 32'hffff_ffff, st);
      chk("mulhu_stalls", st, mul_stalls(32'hffff_ffff));
      chk("mulhu_res", bus_io.out_aluresult, 32'hffff_fffe);
      retire();
      issue_m(3'd1, 32'hffff_ffff, 32'hffff_ffff, st);
      chk("mulh_res", bus_io.out_aluresult, 32'h0);
      retire();
      issue_m(3'd2, 32'hffff_ffff, 32'hffff_ffff, st);
      chk("mulhsu_res", bus_io.out_aluresult, 32'hffff_ffff);
      retire();

      // Divides
      issue_m(3'd4, 32'hffff_fff9, 32'd2, st);
      chk("div_stalls", st, 33);
      chk("div_res", bus_io.out_aluresult, 32'hffff_fffd);
      retire();
      issue_m(3'd6, 32'hffff_fff9, 32'd2, st);
      chk("rem_stalls", st, 33);
      chk("rem_res", bus_io.out_aluresult, 32'hffff_ffff);
      retire();
      issue_m(3'd5, 32'h8000_0000, 32'd3, st);
      chk("divu_res", bus_io.out_aluresult, 32'h2aaa_aaaa);
      retire();
      issue_m(3'd7, 32'h8000_0000, 32'd3, st);
      chk("remu_res", bus_io.out_aluresult, 32'd2);
      retire();
      issue_m(3'd4, 32'd7, 32'hffff_fffe, st);
      chk("div_pos_neg", bus_io.out_aluresult, 32'hffff_fffd);
      retire();
      issue_m(3'd6, 32'd7, 32'hffff_fffe, st);
      chk("rem_pos_neg", bus_io.out_aluresult, 32'd1);
      retire();

      // Special divides: 2-cycle occupancy, stall_e for the start cycle only
      issue_m(3'd4, 32'd5, 32'd0, st);
      chk("div0_stalls", st, 1);
      chk("div0_res", bus_io.out_aluresult, 32'hffff_ffff);
      retire();
      issue_m(3'd7, 32'd5, 32'd0, st);
      chk("remu0_stalls", st, 1);
      chk("remu0_res", bus_io.out_aluresult, 32'd5);
      retire();
      issue_m(3'd4, 32'h8000_0000, 32'hffff_ffff, st);
      chk("divovf_stalls", st, 1);
      chk("divovf_res", bus_io.out_aluresult, 32'h8000_0000);
      retire();
      issue_m(3'd6, 32'h8000_0000, 32'hffff_ffff, st);
      chk("removf_stalls", st, 1);
      chk("removf_res", bus_io.out_aluresult, 32'h0);
      retire();

      // Flush at BUSY cycle 10 drops stall_e at once; the following ADD is normal
      bus_io.in_valid  = 1'b1;
      bus_io.in_muldiv = 1'b1;
      bus_io.in_funct3 = 3'd4;
      bus_io.in_rd1    = 32'd100;
      bus_io.in_rd2    = 32'd7;
      #1;
      chk("flush_start_stall", {31'b0, bus_io.stall_e}, 32'd1);
      repeat (10) step();
      chk("flush_busy10_stall", {31'b0, bus_io.stall_e}, 32'd1);
      bus_io.flush_e = 1'b1;
      #1;
      chk("flush_stall_drop", {31'b0, bus_io.stall_e}, 32'd0);
      step();
      bus_io.flush_e   = 1'b0;
      bus_io.in_muldiv = 1'b0;
      bus_io.in_rd1    = 32'd5;
      bus_io.in_rd2    = 32'd3;
      #1;
      chk("post_flush_stall", {31'b0, bus_io.stall_e}, 32'd0);
      chk("post_flush_add", bus_io.out_aluresult, 32'd8);
      step();

      // hold_e for 3 cycles in DONE keeps the result stable
      issue_m(3'd0, 32'd6, 32'd7, st);
      chk("hold_stalls", st, mul_stalls(32'd7));
      bus_io.hold_e = 1'b1;
      chk("hold_c1", bus_io.out_aluresult, 32'd42);
      step();
      chk("hold_c2", bus_io.out_aluresult, 32'd42);
      chk("hold_c2_stall", {31'b0, bus_io.stall_e}, 32'd0);
      step();
      chk("hold_c3", bus_io.out_aluresult, 32'd42);
      bus_io.hold_e = 1'b0;
      retire();

      // Reset mid-BUSY returns to IDLE with stall_e low after the edge
      bus_io.in_valid  = 1'b1;
      bus_io.in_muldiv = 1'b1;
      bus_io.in_funct3 = 3'd5;
      bus_io.in_rd1    = 32'd1000;
      bus_io.in_rd2    = 32'd3;
      repeat (5) step();
      rst_n = 1'b0;
      bus_io.in_valid = 1'b0;
      #1;
      chk("rst_busy_stall", {31'b0, bus_io.stall_e}, 32'd1);
      step();
      chk("rst_idle_stall", {31'b0, bus_io.stall_e}, 32'd0);
      chk("rst_idle_alu", bus_io.out_aluresult, 32'd1003);
      rst_n = 1'b1;
      step();

      // Forwarded MEM operand is latched at start and ignores later MEM changes
      bus_io.forwarda    = 2'b10;
      bus_io.aluresult_m = 32'd9;
      issue_m(3'd0, 32'd100, 32'd3, st);
      chk("fwd_mul_stalls", st, mul_stalls(32'd3));
      chk("fwd_mul_res", bus_io.out_aluresult, 32'd27);
      retire();
      bus_io.forwarda = 2'b00;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/ex_muldiv_stage.md
# ex_muldiv_stage

Parametrised execute stage for the five-stage core. It adds an iterative RV32M/RV64M multiply/divide unit beside the single-cycle ALU, branch resolution and operand forwarding. Multi-cycle ops hold the pipeline through a `stall_e` request to the hazard unit. The block sits between the ID/EX and EX/MEM pipeline registers as a drop-in replacement for the single-cycle execute stage.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Legal values are 32 and 64.
- `MUL_BITS`, 1: multiplier bits retired per cycle. Legal values are 1, 2, 4 and 8, and must divide `XLEN`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in`  in  id_ex_t  ID/EX bundle. Adds `muldiv` (1) to the existing fields; `funct3` selects the M op.
- `in_valid`  in  1  EX slot holds a real instruction.
- `forwarda`, `forwardb`  in  2 each  forwarding selects from the hazard unit.
- `result_w`, `aluresult_m`  in  XLEN each  forwarded WB and MEM values.
- `flush_e`  in  1  kill the EX instruction; aborts any M op.
- `hold_e`  in  1  external stall (downstream) keeps the EX/MEM register frozen.
- `stall_e`  out  1  EX requests a pipeline freeze of IF/ID/EX.
- `pctarget`  out  XLEN  `in.pc + in.immext`.
- `pcsrc`  out  1  branch/jump taken.
- `out`  out  ex_mem_t  EX/MEM bundle. `aluresult` is muxed with the M result.

## Operation
- Non-M instructions: unchanged single-cycle ALU, branch and forward path. `stall_e` stays 0.
- M op encoding by `funct3`: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- FSM states:
  - IDLE:
    - `start = in_valid & in.muldiv & ~flush_e`.
    - On `start`, latch the forwarded srca/srcb, funct3 and signs, then go to BUSY.
    - Special divides go straight to DONE.
  - BUSY:
    - Multiply: shift-add on magnitudes, `MUL_BITS` per cycle, with a 2·XLEN accumulator.
    - Divide: restoring, 1 quotient bit per cycle.
    - Counter reaches 0 → DONE.
  - DONE:
    - Result is valid on `out.aluresult` and `stall_e` = 0.
    - Go to IDLE unless `hold_e`; stay in DONE while `hold_e` is 1.
- Operands are latched at start. Forwarded MEM/WB values are not re-read while stalled.
- Sign handling:
  - Operands are converted to magnitudes; the result is negated at the end when signs differ.
  - MULHSU treats srca as signed and srcb as unsigned.
  - REM takes the sign of the dividend.
- Special divides, resolved in IDLE:
  - Divisor 0: quotient is all ones; remainder is the dividend.
  - Signed `-2^(XLEN-1) / -1`: quotient is the dividend; remainder is 0.
- Result selection: MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- `flush_e` in any state forces IDLE next cycle and drops `stall_e` immediately (combinational). No result is produced.
- Reset: FSM to IDLE, with counter, accumulator, quotient, remainder and latched operands all 0. The outputs are then:
  - `stall_e` = 0.
  - `out` and `pctarget` are the combinational functions of `in` only.

## Timing
- `stall_e` is combinational: `(IDLE & start & ~special) | BUSY | (IDLE & start & special)`. It is low in DONE.
- Occupancy of EX by one M instruction:
  - Multiply: 1 + XLEN/`MUL_BITS` + 1 cycles.
  - Divide: 1 + XLEN + 1 cycles.
  - Special divide: 2 cycles.
- EX/MEM captures the M result at the rising edge that ends DONE, provided `hold_e` = 0.
- Back-to-back M ops: the second starts in the cycle after DONE. There is no idle gap.
- `pcsrc` and `pctarget` are valid in the cycle the instruction is in EX, independent of the FSM.
- `flush_e` together with `start` in the same cycle: `flush_e` wins and there is no start.

## Configuration
- `EX_MUL_EARLY_OUT_EN` defined:
  - Multiply leaves BUSY as soon as the remaining shifted multiplier magnitude is 0.
  - Minimum is 1 BUSY cycle.
  - Product and sign fix are unchanged.
- `EX_MUL_EARLY_OUT_EN` undefined: multiply always spends exactly XLEN/`MUL_BITS` cycles in BUSY. Latency is deterministic.
- Divide latency is unaffected either way.

## Test plan
1. ADD 5+3 with `muldiv`=0 → `out.aluresult`=8 in the same cycle; `stall_e` never asserts.
2. MUL 7 × -3 (XLEN=32, `MUL_BITS`=1, no early-out):
   - `stall_e` is high for 33 cycles.
   - Result 0xFFFFFFEB is present in the 34th cycle.
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
3. DIV -7/2 → 0xFFFFFFFD, and REM -7/2 → 0xFFFFFFFF, each after 34 cycles. DIVU 0x80000000/3 → 0x2AAAAAAA.
4. Special divides, each with 2-cycle occupancy:
   - DIV 5/0 → 0xFFFFFFFF.
   - REMU 5/0 → 5.
   - DIV 0x80000000/-1 → 0x80000000.
   - REM 0x80000000/-1 → 0.
5. Abort, hold and reset:
   - Start DIV, assert `flush_e` at BUSY cycle 10 → `stall_e` drops that cycle. The next ADD completes normally.
   - `hold_e` for 3 cycles in DONE → result stays stable.
   - `rst_n`=0 mid-BUSY → IDLE with `stall_e`=0 next edge.
6. With `EX_MUL_EARLY_OUT_EN`: MUL 9 × 3 → 27 after 3 BUSY cycles (`MUL_BITS`=1). Forwarded operand via `forwarda`=2'b10 is latched and unaffected by `aluresult_m` changing during BUSY.
